// File: rtl/slow_division.sv
// slow_division
//   Sequential restoring unsigned divider: X / Y -> quot, rem.
//   One quotient bit is resolved per clock, MSB first, so a division always
//   takes exactly WIDTH clocks from the accepting start edge to valid.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   start   launch request, accepted while idle (including the valid cycle)
//   X       dividend, captured on an accepted start
//   Y       divisor, captured on an accepted start
//   valid   one-cycle pulse, quot/rem were updated this cycle
//   quot    quotient, held until the next completion
//   rem     remainder, held until the next completion
//   div0    (only with SLOWDIV_DIV0_FLAG_EN) set on a valid cycle when the
//           captured divisor was zero, cleared on other completions
//
// Build option
//   SLOWDIV_DIV0_FLAG_EN  adds the div0 output; the datapath is unchanged.
//   Y == 0 always yields quot = all ones, rem = X.

module slow_division #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
`ifdef SLOWDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, stateNext;

  // Working registers: the partial remainder carries one guard bit above the
  // divisor width; the dividend register doubles as the quotient collector
  // as its bits are shifted out into the partial remainder.
  logic [WIDTH:0]   prem, premNext;
  logic [WIDTH-1:0] dividend, dividendNext;
  logic [WIDTH-1:0] divisor, divisorNext;
  logic [CW-1:0]    count, countNext;
  logic [WIDTH-1:0] quotNext, remNext;
  logic             validNext;

  // Shift and trial-subtract scratch values. The extra top bit of trial is
  // the borrow: set means the divisor did not fit and the remainder is kept.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

`ifdef SLOWDIV_DIV0_FLAG_EN
  logic div0Next;
`endif

  // Next-state and datapath logic. While idle, a start captures the operands
  // and clears the partial remainder. While running, each cycle shifts
  // {prem, dividend} left, tries to subtract the divisor and records the
  // quotient bit in the vacated dividend LSB. The final iteration publishes
  // the result directly so valid lines up with the Wth clock after start.
  always_comb begin
    stateNext    = state;
    premNext     = prem;
    dividendNext = dividend;
    divisorNext  = divisor;
    countNext    = count;
    quotNext     = quot;
    remNext      = rem;
    validNext    = 1'b0;
    shifted      = '0;
    trial        = '0;
`ifdef SLOWDIV_DIV0_FLAG_EN
    div0Next     = div0;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          dividendNext = X;
          divisorNext  = Y;
          premNext     = '0;
          countNext    = '0;
          stateNext    = RUN;
        end
      end

      RUN: begin
        shifted = {prem, dividend[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
          premNext     = trial[WIDTH:0];
          dividendNext = {dividend[WIDTH-2:0], 1'b1};
        end else begin
          premNext     = shifted[WIDTH:0];
          dividendNext = {dividend[WIDTH-2:0], 1'b0};
        end

        if (count == LAST) begin
          stateNext = IDLE;
          quotNext  = dividendNext;
          remNext   = premNext[WIDTH-1:0];
          validNext = 1'b1;
`ifdef SLOWDIV_DIV0_FLAG_EN
          div0Next  = (divisor == '0);
`endif
        end else begin
          countNext = count + 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything, which also
  // abandons any division in flight without producing a valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prem     <= '0;
      dividend <= '0;
      divisor  <= '0;
      count    <= '0;
      quot     <= '0;
      rem      <= '0;
      valid    <= 1'b0;
`ifdef SLOWDIV_DIV0_FLAG_EN
      div0     <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      prem     <= premNext;
      dividend <= dividendNext;
      divisor  <= divisorNext;
      count    <= countNext;
      quot     <= quotNext;
      rem      <= remNext;
      valid    <= validNext;
`ifdef SLOWDIV_DIV0_FLAG_EN
      div0     <= div0Next;
`endif
    end
  end

endmodule

// File: tb/tb_slow_division.sv
// tb_slow_division
//   Directed bench for slow_division (WIDTH = 4): reset state, directed
//   divisions with hand-computed results, result holding, one-cycle valid,
//   start ignored while busy, reset abort, back-to-back launches, divide by
//   zero and a sweep of all dividends against all non-zero divisors.

module tb_slow_division;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             valid;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
`ifdef SLOWDIV_DIV0_FLAG_EN
  logic             div0;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Last published result, used to check that outputs hold during a run.
  logic [WIDTH-1:0] lastQ = '0;
  logic [WIDTH-1:0] lastR = '0;

  slow_division #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .valid (valid),
    .quot  (quot),
    .rem   (rem)
`ifdef SLOWDIV_DIV0_FLAG_EN
    ,
    .div0  (div0)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Raise start with the given operands for one accepting edge, then
  // scramble X/Y to show the divider works from its captured copies.
  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    start = 1'b1;
    X     = x;
    Y     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    X     = WIDTH'($urandom);
    Y     = WIDTH'($urandom);
  endtask

  // Wait (bounded) for valid, counting edges since the accepting edge.
  // 'already' is the number of edges consumed since acceptance.
  task automatic waitResult(input string tag, input int already,
                            input logic [WIDTH-1:0] expQ,
                            input logic [WIDTH-1:0] expR);
    int lat;
    lat = already;
    while (!valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) begin
        checkOutput({tag, "_hold_quot"}, quot, lastQ);
        checkOutput({tag, "_hold_rem"}, rem, lastR);
      end
    end
    checkOutput({tag, "_latency"}, lat, WIDTH);
    checkOutput({tag, "_quot"}, quot, expQ);
    checkOutput({tag, "_rem"}, rem, expR);
    lastQ = expQ;
    lastR = expR;
  endtask

  task automatic countValids(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) seen++;
    end
    checkOutput(tag, seen, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    X     = '0;
    Y     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_quot", quot, 0);
    checkOutput("reset_rem", rem, 0);
`ifdef SLOWDIV_DIV0_FLAG_EN
    checkOutput("reset_div0", div0, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 15 / 8, then valid must drop after exactly one cycle.
    applyStimulus(4'd15, 4'd8);
    waitResult("t1", 0, 4'd1, 4'd7);
    @(posedge clk);
    #1;
    checkOutput("t1_valid_one_cycle", valid, 0);

    // 10 / 2 with the previous 1/7 held meanwhile.
    applyStimulus(4'd10, 4'd2);
    waitResult("t2", 0, 4'd5, 4'd0);

    // Back-to-back: launched during the valid cycle of the previous result.
    applyStimulus(4'd3, 4'd7);
    waitResult("t3a", 0, 4'd0, 4'd3);
    applyStimulus(4'd15, 4'd1);
    waitResult("t3b", 0, 4'd15, 4'd0);

    // Divide by zero.
    applyStimulus(4'd9, 4'd0);
    waitResult("t4", 0, 4'd15, 4'd9);
`ifdef SLOWDIV_DIV0_FLAG_EN
    checkOutput("t4_div0", div0, 1);
`endif
    applyStimulus(4'd13, 4'd5);
    waitResult("t4b", 0, 4'd2, 4'd3);
`ifdef SLOWDIV_DIV0_FLAG_EN
    checkOutput("t4b_div0", div0, 0);
`endif

    // Start pulsed while running is ignored.
    applyStimulus(4'd15, 4'd8);
    @(negedge clk);
    start = 1'b1;
    X     = 4'd6;
    Y     = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitResult("t5", 1, 4'd1, 4'd7);
    countValids("t5_no_extra_valid", 8);

    // Reset in the middle of a division aborts it.
    applyStimulus(4'd15, 4'd8);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_reset_valid", valid, 0);
    checkOutput("t6_reset_quot", quot, 0);
    checkOutput("t6_reset_rem", rem, 0);
    lastQ = '0;
    lastR = '0;
    countValids("t6_no_valid", 8);
    applyStimulus(4'd14, 4'd4);
    waitResult("t6b", 0, 4'd3, 4'd2);

    // Every dividend against every non-zero divisor.
    for (int x = 0; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        applyStimulus(WIDTH'(x), WIDTH'(y));
        waitResult("sweep", 0, WIDTH'(x / y), WIDTH'(x % y));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
